// File: rtl/status_reg_stack_if.sv
// rtl/status_reg_stack_if.sv - control/flag bundle between sequencer and status register stack
interface status_reg_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             upd_en;
  logic [WIDTH-1:0] upd_mask;
  logic [WIDTH-1:0] upd_val;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic             ld_en;
  logic [WIDTH-1:0] ld_val;
  logic             save;
  logic             restore;
  logic             brk;
  logic             err_clr;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] p_img;
  logic             dec_mode;
  logic [CW-1:0]    depth_cnt;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (
    output upd_en, upd_mask, upd_val, set_mask, clr_mask, ld_en, ld_val,
           save, restore, brk, err_clr,
    input  p_q, p_img, dec_mode, depth_cnt, full, empty, ovf, unf
  );

  modport slave (
    input  upd_en, upd_mask, upd_val, set_mask, clr_mask, ld_en, ld_val,
           save, restore, brk, err_clr,
    output p_q, p_img, dec_mode, depth_cnt, full, empty, ovf, unf
  );
endinterface

// File: rtl/status_reg_stack.sv
// rtl/status_reg_stack.sv - NV1BDIZC status register with LIFO shadow stack for nested save/restore
module status_reg_stack #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'h24,
  parameter int               B_BIT     = 4,
  parameter int               ONE_BIT   = 5
) (
  input logic               clk,
  input logic               C_clr,
  status_reg_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // B is never stored and bit 5 always reads as one
  function automatic logic [WIDTH-1:0] fix_bits(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r          = v;
    r[B_BIT]   = 1'b0;
    r[ONE_BIT] = 1'b1;
    return r;
  endfunction

  logic [WIDTH-1:0] p_r;
  logic [CW-1:0]    cnt_r;
  logic             ovf_r;
  logic             unf_r;
  logic [WIDTH-1:0] stk [2**AW];

  logic             is_full;
  logic             is_empty;
  logic [CW-1:0]    top_cnt;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic [WIDTH-1:0] eff_mask;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] img;
  logic             do_pop;
  logic             do_push;
  logic             ovf_set;
  logic             unf_set;

  always_comb begin
    is_full  = (cnt_r == CW'(DEPTH));
    is_empty = (cnt_r == '0);
    top_cnt  = cnt_r - CW'(1);
    top_idx  = top_cnt[AW-1:0];
    push_idx = cnt_r[AW-1:0];
    eff_mask = bus.upd_en ? bus.upd_mask : '0;
    base     = bus.ld_en ? bus.ld_val : ((p_r & ~eff_mask) | (bus.upd_val & eff_mask));
    nxt      = fix_bits((base & ~bus.clr_mask) | bus.set_mask);
    // save+restore on an empty stack degrades to a plain save
    do_pop   = bus.restore && !is_empty;
    do_push  = bus.save && !do_pop && !is_full;
    ovf_set  = bus.save && !do_pop && is_full;
    unf_set  = bus.restore && is_empty && !bus.save;
  end

  always_ff @(posedge clk or posedge C_clr) begin
    if (C_clr) begin
      p_r   <= fix_bits(RESET_VAL);
      cnt_r <= '0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (do_pop) begin
        p_r <= fix_bits(stk[top_idx]);
        if (!bus.save) cnt_r <= top_cnt;
      end else begin
        p_r <= nxt;
        if (do_push) cnt_r <= cnt_r + CW'(1);
      end
      ovf_r <= ovf_set | (ovf_r & ~bus.err_clr);
      unf_r <= unf_set | (unf_r & ~bus.err_clr);
    end
  end

  // Contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge clk) begin
    if (do_pop && bus.save) stk[top_idx] <= p_r;
    else if (do_push) stk[push_idx] <= p_r;
  end

  always_comb begin
    img          = p_r;
    img[B_BIT]   = bus.brk;
    img[ONE_BIT] = 1'b1;
  end

  assign bus.p_q       = p_r;
  assign bus.p_img     = img;
  assign bus.dec_mode  = p_r[3];
  assign bus.depth_cnt = cnt_r;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.ovf       = ovf_r;
  assign bus.unf       = unf_r;
endmodule

// File: tb/tb_status_reg_stack.sv
// tb/tb_status_reg_stack.sv - randomized and directed bench for status_reg_stack
module tb_status_reg_stack;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic C_clr = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   cmp_en = 1'b0;

  logic [7:0] m_p;
  logic [7:0] m_stk[$];
  bit         m_ovf;
  bit         m_unf;

  status_reg_stack_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

  status_reg_stack #(
    .WIDTH(8), .DEPTH(DEPTH), .RESET_VAL(8'h24), .B_BIT(4), .ONE_BIT(5)
  ) dut (
    .clk  (clk),
    .C_clr(C_clr),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 8'h24;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_clock();
    logic [7:0] um, t, n, top;
    bit new_ovf, new_unf;
    new_ovf = 0;
    new_unf = 0;
    um = bus.upd_en ? bus.upd_mask : 8'h00;
    t = bus.ld_en ? bus.ld_val : ((m_p & ~um) | (bus.upd_val & um));
    n = (t & ~bus.clr_mask) | bus.set_mask;
    n[4] = 1'b0;
    n[5] = 1'b1;
    if (bus.restore && m_stk.size() > 0) begin
      top = m_stk.pop_back();
      if (bus.save) m_stk.push_back(m_p);
      m_p = top;
    end else begin
      if (bus.save) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(m_p);
        else new_ovf = 1;
      end else if (bus.restore) begin
        new_unf = 1;
      end
      m_p = n;
    end
    m_ovf = new_ovf | (m_ovf & !bus.err_clr);
    m_unf = new_unf | (m_unf & !bus.err_clr);
  endtask

  task automatic idle();
    bus.upd_en = 0; bus.upd_mask = 0; bus.upd_val = 0;
    bus.set_mask = 0; bus.clr_mask = 0; bus.ld_en = 0; bus.ld_val = 0;
    bus.save = 0; bus.restore = 0; bus.brk = 0; bus.err_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    #1;
    idle();
  endtask

  task automatic load_save(input logic [7:0] v, input bit sv);
    bus.ld_en = 1; bus.ld_val = v; bus.save = sv;
    step();
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [7:0] ei;
      ei = m_p;
      ei[4] = bus.brk;
      ei[5] = 1'b1;
      chk("p_q", bus.p_q, m_p);
      chk("p_img", bus.p_img, ei);
      chk("dec_mode", bus.dec_mode, m_p[3]);
      chk("depth_cnt", bus.depth_cnt, m_stk.size());
      chk("full", bus.full, m_stk.size() == DEPTH);
      chk("empty", bus.empty, m_stk.size() == 0);
      chk("ovf", bus.ovf, m_ovf);
      chk("unf", bus.unf, m_unf);
    end
  end

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    C_clr = 0;
    cmp_en = 1;
    chk("rst_p_q", bus.p_q, 8'h24);
    chk("rst_empty", bus.empty, 1);

    bus.upd_en = 1; bus.upd_mask = 8'h83; bus.upd_val = 8'h82;
    step();
    chk("upd_p_q", bus.p_q, 8'hA6);
    bus.upd_en = 1; bus.upd_mask = 8'h83; bus.upd_val = 8'h82;
    bus.set_mask = 8'h01; bus.clr_mask = 8'h01;
    step();
    chk("set_wins", bus.p_q, 8'hA7);

    load_save(8'hFF, 0);
    chk("ld_p_q", bus.p_q, 8'hEF);
    bus.brk = 1; #1;
    chk("img_brk1", bus.p_img, 8'hFF);
    bus.brk = 0; #1;
    chk("img_brk0", bus.p_img, 8'hEF);

    load_save(8'h24, 0);
    load_save(8'h25, 1);
    load_save(8'h26, 1);
    load_save(8'h27, 1);
    chk("not_full3", bus.full, 0);
    load_save(8'hA4, 1);
    chk("full4", bus.full, 1);
    chk("no_ovf4", bus.ovf, 0);
    bus.save = 1;
    step();
    chk("ovf5", bus.ovf, 1);
    chk("depth5", bus.depth_cnt, 4);
    bus.restore = 1; step(); chk("pop1", bus.p_q, 8'h27);
    bus.restore = 1; step(); chk("pop2", bus.p_q, 8'h26);
    bus.restore = 1; step(); chk("pop3", bus.p_q, 8'h25);
    bus.restore = 1; step(); chk("pop4", bus.p_q, 8'h24);
    chk("empty4", bus.empty, 1);
    bus.err_clr = 1; step();
    chk("ovf_clr", bus.ovf, 0);

    bus.restore = 1; bus.ld_en = 1; bus.ld_val = 8'h03;
    step();
    chk("unf_set", bus.unf, 1);
    chk("unf_p_q", bus.p_q, 8'h23);
    bus.err_clr = 1; step();
    chk("unf_clr", bus.unf, 0);

    load_save(8'h24, 0);
    load_save(8'hE7, 1);
    bus.save = 1; bus.restore = 1;
    step();
    chk("swap_p_q", bus.p_q, 8'h24);
    chk("swap_depth", bus.depth_cnt, 1);
    bus.restore = 1; step();
    chk("swap_top", bus.p_q, 8'hE7);

    load_save(8'h30, 1);
    load_save(8'h31, 1);
    bus.ld_en = 1; bus.ld_val = 8'hC3; bus.save = 1;
    C_clr = 1;
    model_reset();
    #1;
    chk("arst_p_q", bus.p_q, 8'h24);
    chk("arst_depth", bus.depth_cnt, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_errs", {bus.ovf, bus.unf}, 2'b00);
    @(negedge clk);
    #1;
    idle();
    C_clr = 0;

    for (int i = 0; i < 800; i++) begin
      bus.upd_en   = ($urandom_range(0, 1) == 1);
      bus.upd_mask = 8'($urandom);
      bus.upd_val  = 8'($urandom);
      bus.set_mask = 8'($urandom & $urandom & $urandom);
      bus.clr_mask = 8'($urandom & $urandom & $urandom);
      bus.ld_en    = ($urandom_range(0, 6) == 0);
      bus.ld_val   = 8'($urandom);
      bus.save     = ($urandom_range(0, 2) == 0);
      bus.restore  = ($urandom_range(0, 2) == 0);
      bus.brk      = 1'($urandom);
      bus.err_clr  = ($urandom_range(0, 9) == 0);
      step();
    end

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
